decode_queue: RTL and testbench



---
 rtl/decode_queue.sv | 215 +++++++++++++++++++++
 tb/tb_decode_queue.sv | 265 ++++++++++++++++++++++++++
 2 files changed

// File: rtl/decode_queue.sv
// Registered RV32 decode stage feeding a DEPTH-entry circular FIFO of decoded packets.
// Optional same-cycle bypass for an empty queue: define DECODE_QUEUE_BYPASS_EN.
package ooop_types;
  typedef enum logic [3:0] {
    ALU_ADD, ALU_SUB, ALU_AND, ALU_OR, ALU_XOR,
    ALU_SLL, ALU_SRL, ALU_SRA, ALU_SLT, ALU_SLTU
  } alu_op_t;

  typedef enum logic [1:0] {LS_B, LS_H, LS_W} ls_size_t;

  typedef struct packed {
    logic [31:0] pc;
    logic [4:0]  rd;
    logic [4:0]  rs1;
    logic [4:0]  rs2;
    logic        rd_used;
    logic        rs1_used;
    logic        rs2_used;
    logic [31:0] imm;
    alu_op_t     alu_op;
    logic        is_load;
    logic        is_store;
    logic        is_branch;
    logic        is_jump;
    ls_size_t    ls_size;
    logic        unsigned_load;
    logic [2:0]  br_cond;
  } decode_pkt_t;
endpackage

module decode_queue
  import ooop_types::*;
#(
  parameter int DEPTH = 4,
  parameter int CNT_W = $clog2(DEPTH) + 1
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             flush,
  input  logic             valid_in,
  output logic             ready_out,
  input  logic [31:0]      pc_in,
  input  logic [31:0]      instr_in,
  output logic             valid_out,
  input  logic             ready_in,
  output decode_pkt_t      pkt_out,
  output logic             illegal_out,
  output logic [CNT_W-1:0] count
);
  localparam int PTR_W = $clog2(DEPTH);

  decode_pkt_t      mem [DEPTH];
  logic             ill_mem [DEPTH];
  logic [PTR_W-1:0] wr_ptr, rd_ptr;
  decode_pkt_t      dec;
  logic             dec_ill;
  logic             push, pop, fifo_valid, bypass;

  logic [6:0]  opcode;
  logic [2:0]  f3;
  logic [6:0]  f7;
  logic [31:0] imm_i, imm_s, imm_b, imm_u, imm_j, shamt;

  assign opcode = instr_in[6:0];
  assign f3     = instr_in[14:12];
  assign f7     = instr_in[31:25];
  assign imm_i  = {{20{instr_in[31]}}, instr_in[31:20]};
  assign imm_s  = {{20{instr_in[31]}}, instr_in[31:25], instr_in[11:7]};
  assign imm_b  = {{19{instr_in[31]}}, instr_in[31], instr_in[7], instr_in[30:25],
                   instr_in[11:8], 1'b0};
  assign imm_u  = {instr_in[31:12], 12'd0};
  assign imm_j  = {{11{instr_in[31]}}, instr_in[31], instr_in[19:12], instr_in[20],
                   instr_in[30:21], 1'b0};
  assign shamt  = {27'd0, instr_in[24:20]};

  always_comb begin
    dec     = '0;
    dec_ill = 1'b0;
    case (opcode)
      7'b0010011: begin  // OP-IMM; shifts carry the zero-extended shamt as imm
        dec.rd = instr_in[11:7]; dec.rd_used = 1'b1;
        dec.rs1 = instr_in[19:15]; dec.rs1_used = 1'b1;
        dec.imm = imm_i;
        case (f3)
          3'b010: dec.alu_op = ALU_SLT;
          3'b011: dec.alu_op = ALU_SLTU;
          3'b100: dec.alu_op = ALU_XOR;
          3'b110: dec.alu_op = ALU_OR;
          3'b111: dec.alu_op = ALU_AND;
          3'b001: begin
            dec.alu_op = ALU_SLL; dec.imm = shamt;
            dec_ill = (f7 != 7'd0);
          end
          3'b101: begin
            dec.alu_op = instr_in[30] ? ALU_SRA : ALU_SRL; dec.imm = shamt;
            dec_ill = ({f7[6], f7[4:0]} != 6'd0);
          end
          default: dec.alu_op = ALU_ADD;
        endcase
      end
      7'b0110011: begin
        dec.rd = instr_in[11:7]; dec.rd_used = 1'b1;
        dec.rs1 = instr_in[19:15]; dec.rs1_used = 1'b1;
        dec.rs2 = instr_in[24:20]; dec.rs2_used = 1'b1;
        if (f7 == 7'b0000000) begin
          case (f3)
            3'b000: dec.alu_op = ALU_ADD;
            3'b001: dec.alu_op = ALU_SLL;
            3'b010: dec.alu_op = ALU_SLT;
            3'b011: dec.alu_op = ALU_SLTU;
            3'b100: dec.alu_op = ALU_XOR;
            3'b101: dec.alu_op = ALU_SRL;
            3'b110: dec.alu_op = ALU_OR;
            default: dec.alu_op = ALU_AND;
          endcase
        end else if (f7 == 7'b0100000 && f3 == 3'b000) dec.alu_op = ALU_SUB;
        else if (f7 == 7'b0100000 && f3 == 3'b101) dec.alu_op = ALU_SRA;
        else dec_ill = 1'b1;
      end
      7'b0000011: begin
        dec.rd = instr_in[11:7]; dec.rd_used = 1'b1;
        dec.rs1 = instr_in[19:15]; dec.rs1_used = 1'b1;
        dec.imm = imm_i; dec.is_load = 1'b1;
        dec.unsigned_load = f3[2];
        case (f3)
          3'b000, 3'b100: dec.ls_size = LS_B;
          3'b001, 3'b101: dec.ls_size = LS_H;
          3'b010:         dec.ls_size = LS_W;
          default:        dec_ill = 1'b1;
        endcase
      end
      7'b0100011: begin
        dec.rs1 = instr_in[19:15]; dec.rs1_used = 1'b1;
        dec.rs2 = instr_in[24:20]; dec.rs2_used = 1'b1;
        dec.imm = imm_s; dec.is_store = 1'b1;
        case (f3)
          3'b000:  dec.ls_size = LS_B;
          3'b001:  dec.ls_size = LS_H;
          3'b010:  dec.ls_size = LS_W;
          default: dec_ill = 1'b1;
        endcase
      end
      7'b1100011: begin
        dec.rs1 = instr_in[19:15]; dec.rs1_used = 1'b1;
        dec.rs2 = instr_in[24:20]; dec.rs2_used = 1'b1;
        dec.imm = imm_b; dec.is_branch = 1'b1; dec.br_cond = f3;
        dec_ill = (f3 == 3'b010) || (f3 == 3'b011);
      end
      7'b0110111: begin
        dec.rd = instr_in[11:7]; dec.rd_used = 1'b1; dec.imm = imm_u;
      end
      7'b1101111: begin
        dec.rd = instr_in[11:7]; dec.rd_used = 1'b1;
        dec.imm = imm_j; dec.is_jump = 1'b1;
      end
      7'b1100111: begin
        dec.rd = instr_in[11:7]; dec.rd_used = 1'b1;
        dec.rs1 = instr_in[19:15]; dec.rs1_used = 1'b1;
        dec.imm = imm_i; dec.is_jump = 1'b1;
        dec_ill = (f3 != 3'b000);
      end
      default: dec_ill = 1'b1;
    endcase
    if (dec.rd == 5'd0) dec.rd_used = 1'b0;
    // Illegal entries still travel in order so the ROB can trap on them.
    if (dec_ill) dec = '0;
    dec.pc = pc_in;
  end

  assign fifo_valid = (count != '0);
  assign ready_out  = (count != CNT_W'(DEPTH));

`ifdef DECODE_QUEUE_BYPASS_EN
  assign bypass      = !fifo_valid && valid_in && ready_in && !flush;
  assign valid_out   = fifo_valid || valid_in;
  assign pkt_out     = fifo_valid ? mem[rd_ptr] : dec;
  assign illegal_out = fifo_valid ? ill_mem[rd_ptr] : dec_ill;
`else
  assign bypass      = 1'b0;
  assign valid_out   = fifo_valid;
  assign pkt_out     = mem[rd_ptr];
  assign illegal_out = ill_mem[rd_ptr];
`endif

  assign push = valid_in && ready_out && !bypass;
  assign pop  = fifo_valid && ready_in;

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
      for (int i = 0; i < DEPTH; i++) begin
        mem[i]     <= '0;
        ill_mem[i] <= 1'b0;
      end
    end else if (flush) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (push) begin
        mem[wr_ptr]     <= dec;
        ill_mem[wr_ptr] <= dec_ill;
        wr_ptr          <= wr_ptr + 1'b1;
      end
      if (pop) rd_ptr <= rd_ptr + 1'b1;
      case ({push, pop})
        2'b10:   count <= count + 1'b1;
        2'b01:   count <= count - 1'b1;
        default: count <= count;
      endcase
    end
  end
endmodule

// File: tb/tb_decode_queue.sv
// Scoreboard bench for decode_queue: stimulus pushes hand-decoded packets, a negedge
// monitor pops and compares whenever the head is consumed.
module tb_decode_queue;
  import ooop_types::*;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        flush = 1'b0;
  logic        valid_in = 1'b0;
  logic        ready_in = 1'b0;
  logic [31:0] pc_in = '0;
  logic [31:0] instr_in = '0;
  logic        ready_out, valid_out, illegal_out;
  decode_pkt_t pkt_out;
  logic [2:0]  count;

  decode_queue #(.DEPTH(4)) dut (
    .clk(clk), .rst_n(rst_n), .flush(flush), .valid_in(valid_in),
    .ready_out(ready_out), .pc_in(pc_in), .instr_in(instr_in),
    .valid_out(valid_out), .ready_in(ready_in), .pkt_out(pkt_out),
    .illegal_out(illegal_out), .count(count)
  );

  always #5 clk = ~clk;

  typedef struct packed {
    decode_pkt_t pkt;
    logic        ill;
  } exp_t;

  exp_t sb[$];
  int total = 0;
  int bad = 0;

  task automatic chk(input string name, input logic [127:0] act, input logic [127:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  // used = {rd_used, rs1_used, rs2_used}; flags = {is_load, is_store, is_branch, is_jump}
  function automatic decode_pkt_t mk(input logic [31:0] pc, input logic [4:0] rd,
      input logic [4:0] rs1, input logic [4:0] rs2, input logic [2:0] used,
      input logic [31:0] imm, input alu_op_t alu, input logic [3:0] flags,
      input ls_size_t lss, input logic uns, input logic [2:0] brc);
    decode_pkt_t p;
    p = '0;
    p.pc = pc; p.rd = rd; p.rs1 = rs1; p.rs2 = rs2;
    {p.rd_used, p.rs1_used, p.rs2_used} = used;
    p.imm = imm; p.alu_op = alu;
    {p.is_load, p.is_store, p.is_branch, p.is_jump} = flags;
    p.ls_size = lss; p.unsigned_load = uns; p.br_cond = brc;
    return p;
  endfunction

  function automatic decode_pkt_t ill_pkt(input logic [31:0] pc);
    decode_pkt_t p;
    p = '0;
    p.pc = pc;
    return p;
  endfunction

  always @(negedge clk) begin
    if (rst_n && !flush && valid_out && ready_in) begin
      if (sb.size() == 0) begin
        total++;
        bad++;
        $display("FAIL unexpected_out: got pc %0h expected no output", pkt_out.pc);
      end else begin
        exp_t e;
        e = sb.pop_front();
        chk("pkt", 128'(pkt_out), 128'(e.pkt));
        chk("illegal", 128'(illegal_out), 128'(e.ill));
      end
    end
  end

  task automatic wait_accept();
    bit acc;
    int n;
    acc = 1'b0;
    n = 0;
    while (!acc && n < 50) begin
      @(negedge clk);
      acc = ready_out && !flush;
      @(posedge clk);
      #1;
      n++;
    end
    if (!acc) begin
      total++;
      bad++;
      $display("FAIL accept_timeout: got no accept expected accept within 50 cycles");
    end
    valid_in = 1'b0;
  endtask

  task automatic issue(input logic [31:0] pc, input logic [31:0] instr,
                       input decode_pkt_t e, input logic ill);
    sb.push_back({e, ill});
    pc_in = pc;
    instr_in = instr;
    valid_in = 1'b1;
    wait_accept();
  endtask

  task automatic wait_empty();
    int n;
    n = 0;
    while ((count != 0 || sb.size() != 0) && n < 100) begin
      @(posedge clk);
      #1;
      n++;
    end
    if (n >= 100) begin
      total++;
      bad++;
      $display("FAIL drain_timeout: got count %0d expected 0", count);
    end
  endtask

  function automatic logic [31:0] addi_enc(input int i);
    logic [11:0] im;
    logic [4:0]  rd;
    im = 12'(i);
    rd = 5'(i + 1);
    return {im, 5'd0, 3'b000, rd, 7'h13};
  endfunction

  initial begin
    #200000;
    $display("FAIL watchdog: got no finish expected finish");
    $fatal(1, "watchdog");
  end

  initial begin
    repeat (3) @(posedge clk);
    #1;
    chk("rst_count", 128'(count), 128'(0));
    chk("rst_valid_out", 128'(valid_out), 128'(0));
    chk("rst_ready_out", 128'(ready_out), 128'(1));
    chk("rst_pkt_out", 128'(pkt_out), 128'(0));
    chk("rst_illegal", 128'(illegal_out), 128'(0));
    rst_n = 1'b1;
    @(posedge clk);
    #1;

    // addi x1,x0,5 with one-cycle latency
    ready_in = 1'b1;
    sb.push_back({mk(32'h100, 5'd1, 5'd0, 5'd0, 3'b110, 32'd5, ALU_ADD, 4'b0000, LS_B, 1'b0, 3'd0), 1'b0});
    pc_in = 32'h100;
    instr_in = 32'h00500093;
    valid_in = 1'b1;
    @(posedge clk);
    #1;
    valid_in = 1'b0;
`ifndef DECODE_QUEUE_BYPASS_EN
    chk("lat_valid_out", 128'(valid_out), 128'(1));
    chk("lat_count", 128'(count), 128'(1));
`endif
    @(posedge clk);
    #1;
    chk("after_pop_count", 128'(count), 128'(0));

    // Fill to DEPTH with downstream stalled
    ready_in = 1'b0;
    issue(32'h200, 32'h00500093, mk(32'h200, 5'd1, 5'd0, 5'd0, 3'b110, 32'd5, ALU_ADD, 4'b0000, LS_B, 1'b0, 3'd0), 1'b0);
    issue(32'h204, 32'h40208133, mk(32'h204, 5'd2, 5'd1, 5'd2, 3'b111, 32'd0, ALU_SUB, 4'b0000, LS_B, 1'b0, 3'd0), 1'b0);
    issue(32'h208, 32'h0020F1B3, mk(32'h208, 5'd3, 5'd1, 5'd2, 3'b111, 32'd0, ALU_AND, 4'b0000, LS_B, 1'b0, 3'd0), 1'b0);
    issue(32'h20C, 32'h4030D213, mk(32'h20C, 5'd4, 5'd1, 5'd0, 3'b110, 32'd3, ALU_SRA, 4'b0000, LS_B, 1'b0, 3'd0), 1'b0);
    chk("full_count", 128'(count), 128'(4));
    chk("full_ready_out", 128'(ready_out), 128'(0));
    sb.push_back({mk(32'h210, 5'd10, 5'd0, 5'd0, 3'b110, 32'd10, ALU_ADD, 4'b0000, LS_B, 1'b0, 3'd0), 1'b0});
    pc_in = 32'h210;
    instr_in = 32'h00A00513;
    valid_in = 1'b1;
    repeat (3) @(posedge clk);
    #1;
    chk("held_count", 128'(count), 128'(4));
    ready_in = 1'b1;
    wait_accept();
    wait_empty();

    // Memory ops, branch, jump, lui, nop back-to-back with draining
    issue(32'h300, 32'h0040A183, mk(32'h300, 5'd3, 5'd1, 5'd0, 3'b110, 32'd4, ALU_ADD, 4'b1000, LS_W, 1'b0, 3'd0), 1'b0);
    issue(32'h304, 32'h0020A423, mk(32'h304, 5'd0, 5'd1, 5'd2, 3'b011, 32'd8, ALU_ADD, 4'b0100, LS_W, 1'b0, 3'd0), 1'b0);
    issue(32'h308, 32'h0040C183, mk(32'h308, 5'd3, 5'd1, 5'd0, 3'b110, 32'd4, ALU_ADD, 4'b1000, LS_B, 1'b1, 3'd0), 1'b0);
    issue(32'h30C, 32'h00208463, mk(32'h30C, 5'd0, 5'd1, 5'd2, 3'b011, 32'd8, ALU_ADD, 4'b0010, LS_B, 1'b0, 3'd0), 1'b0);
    issue(32'h310, 32'h010000EF, mk(32'h310, 5'd1, 5'd0, 5'd0, 3'b100, 32'd16, ALU_ADD, 4'b0001, LS_B, 1'b0, 3'd0), 1'b0);
    issue(32'h314, 32'h123452B7, mk(32'h314, 5'd5, 5'd0, 5'd0, 3'b100, 32'h12345000, ALU_ADD, 4'b0000, LS_B, 1'b0, 3'd0), 1'b0);
    issue(32'h318, 32'h00000013, mk(32'h318, 5'd0, 5'd0, 5'd0, 3'b010, 32'd0, ALU_ADD, 4'b0000, LS_B, 1'b0, 3'd0), 1'b0);
    wait_empty();

    // Illegal encodings: unknown opcode, bad branch/load/store funct3, M-extension op
    issue(32'h400, 32'hFFFFFFFF, ill_pkt(32'h400), 1'b1);
    issue(32'h404, 32'h0020A463, ill_pkt(32'h404), 1'b1);
    issue(32'h408, 32'h0040B183, ill_pkt(32'h408), 1'b1);
    issue(32'h40C, 32'h0020B023, ill_pkt(32'h40C), 1'b1);
    issue(32'h410, 32'h022080B3, ill_pkt(32'h410), 1'b1);
    wait_empty();

    // Flush with a concurrent push at count=3
    ready_in = 1'b0;
    for (int i = 0; i < 3; i++)
      issue(32'h500 + 32'(4 * i), addi_enc(i),
            mk(32'h500 + 32'(4 * i), 5'(i + 1), 5'd0, 5'd0, 3'b110, 32'(i), ALU_ADD, 4'b0000, LS_B, 1'b0, 3'd0), 1'b0);
    chk("pre_flush_count", 128'(count), 128'(3));
    flush = 1'b1;
    pc_in = 32'h50C;
    instr_in = addi_enc(3);
    valid_in = 1'b1;
    @(posedge clk);
    #1;
    flush = 1'b0;
    valid_in = 1'b0;
    sb.delete();
    chk("flush_count", 128'(count), 128'(0));
    chk("flush_valid_out", 128'(valid_out), 128'(0));
    ready_in = 1'b1;
    repeat (3) @(posedge clk);
    #1;
    chk("flush_dropped", 128'(valid_out), 128'(0));

    // Steady push+pop across pointer wrap
    ready_in = 1'b0;
    for (int i = 0; i < 2; i++)
      issue(32'h600 + 32'(4 * i), addi_enc(i),
            mk(32'h600 + 32'(4 * i), 5'(i + 1), 5'd0, 5'd0, 3'b110, 32'(i), ALU_ADD, 4'b0000, LS_B, 1'b0, 3'd0), 1'b0);
    ready_in = 1'b1;
    for (int i = 2; i < 12; i++) begin
      sb.push_back({mk(32'h600 + 32'(4 * i), 5'(i + 1), 5'd0, 5'd0, 3'b110, 32'(i), ALU_ADD, 4'b0000, LS_B, 1'b0, 3'd0), 1'b0});
      pc_in = 32'h600 + 32'(4 * i);
      instr_in = addi_enc(i);
      valid_in = 1'b1;
      @(posedge clk);
      #1;
      chk("stream_count", 128'(count), 128'(2));
    end
    valid_in = 1'b0;
    wait_empty();

`ifdef DECODE_QUEUE_BYPASS_EN
    sb.push_back({mk(32'h700, 5'd1, 5'd0, 5'd0, 3'b110, 32'd5, ALU_ADD, 4'b0000, LS_B, 1'b0, 3'd0), 1'b0});
    pc_in = 32'h700;
    instr_in = 32'h00500093;
    valid_in = 1'b1;
    #1;
    chk("bypass_valid_out", 128'(valid_out), 128'(1));
    chk("bypass_pc", 128'(pkt_out.pc), 128'(32'h700));
    @(posedge clk);
    #1;
    valid_in = 1'b0;
    chk("bypass_count", 128'(count), 128'(0));
`endif

    repeat (2) @(posedge clk);
    #1;
    chk("sb_drained", 128'(sb.size()), 128'(0));
    chk("end_count", 128'(count), 128'(0));
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
